// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cache-side memory bus: FSM states, line geometry
// and small decode helpers used by the bus initiator.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WDONE = 3'd3,
        RWAIT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int BEATS_PER_LINE   = 8;
    localparam int WRITE_LEAD_BEATS = 1;
    localparam int LINE_OFFSET_BITS = 5;

    // States in which the initiator is waiting on resp_m_to_c.
    function automatic logic is_waiting(input state_t s);
        logic w;
        case (s)
            ADDR, WDATA, WDONE, RWAIT: w = 1'b1;
            default:                   w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cacheline_bus_initiator_if.sv
// Multiplexed c_to_m / m_to_c memory bus between the cache initiator and the
// memory responder.
interface cacheline_bus_initiator_if #(
    parameter int BUS_WIDTH = 32
);

    logic                 read_en_c_to_m;
    logic                 write_en_c_to_m;
    logic                 address_on_c_to_m;
    logic                 data_on_c_to_m;
    logic [BUS_WIDTH-1:0] address_data_bus_c_to_m;
    logic                 resp_m_to_c;
    logic [BUS_WIDTH-1:0] address_data_bus_m_to_c;

    modport master (
        output read_en_c_to_m,
        output write_en_c_to_m,
        output address_on_c_to_m,
        output data_on_c_to_m,
        output address_data_bus_c_to_m,
        input  resp_m_to_c,
        input  address_data_bus_m_to_c
    );

    modport slave (
        input  read_en_c_to_m,
        input  write_en_c_to_m,
        input  address_on_c_to_m,
        input  data_on_c_to_m,
        input  address_data_bus_c_to_m,
        output resp_m_to_c,
        output address_data_bus_m_to_c
    );

endinterface

// File: rtl/cacheline_bus_initiator.sv
// Serializes one cacheline read or write from the cache DFP port onto the
// 32-bit memory bus as an address beat plus data beats; all outputs registered.
module cacheline_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int LINE_WIDTH = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] dfp_addr,
    input  logic                  dfp_read,
    input  logic                  dfp_write,
    input  logic [LINE_WIDTH-1:0] dfp_wdata,
    output logic [LINE_WIDTH-1:0] dfp_rdata,
    output logic                  dfp_resp,
    cacheline_bus_initiator_if.master bus,
    output logic                  err
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [3:0] LAST_WRITE_BEAT = 4'(BEATS_PER_LINE + WRITE_LEAD_BEATS - 1);
    localparam logic [3:0] LAST_READ_BEAT  = 4'(BEATS_PER_LINE - 1);

    state_t                state_r, state_s;
    logic [3:0]            beat_r, beat_s;
    logic [LINE_WIDTH-1:0] line_r, line_s;
    logic [WAIT_W-1:0]     wait_cnt_r, wait_s;
    logic                  read_en_r, read_en_s;
    logic                  write_en_r, write_en_s;
    logic                  address_on_r, address_on_s;
    logic                  data_on_r, data_on_s;
    logic [BUS_WIDTH-1:0]  bus_r, bus_s;
    logic                  dfp_resp_r, dfp_resp_s;
    logic                  err_r, err_s;
    logic                  capture_s;
    logic                  timeout_s;
    logic [BUS_WIDTH-1:0]  line_words_s [BEATS_PER_LINE];
    logic                  unused_addr_bits_s;

    assign unused_addr_bits_s = ^dfp_addr[LINE_OFFSET_BITS-1:0];

    // Word view of the line buffer feeding the write-data mux.
    always_comb begin
        for (int k = 0; k < BEATS_PER_LINE; k++) begin
            line_words_s[k] = line_r[k*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s      = state_r;
        beat_s       = beat_r;
        line_s       = line_r;
        read_en_s    = read_en_r;
        write_en_s   = write_en_r;
        address_on_s = address_on_r;
        data_on_s    = data_on_r;
        bus_s        = bus_r;
        dfp_resp_s   = 1'b0;
        err_s        = err_r;
        capture_s    = 1'b0;

        // Per-beat wait counter: restarts on every ack and outside bus phases.
        if (!is_waiting(state_r) || bus.resp_m_to_c) begin
            wait_s = '0;
        end else begin
            wait_s = wait_cnt_r + WAIT_W'(1);
        end

        timeout_s = (TIMEOUT != 0) && is_waiting(state_r) &&
                    !bus.resp_m_to_c && (wait_cnt_r == WAIT_LAST);

        case (state_r)
            IDLE: begin
                if (dfp_read || dfp_write) begin
                    read_en_s    = dfp_read;
                    write_en_s   = !dfp_read;
                    address_on_s = 1'b1;
                    bus_s        = {dfp_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                                    {LINE_OFFSET_BITS{1'b0}}};
                    line_s       = dfp_read ? line_r : dfp_wdata;
                    beat_s       = 4'd0;
                    state_s      = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (bus.resp_m_to_c) begin
                    address_on_s = 1'b0;
                    bus_s        = '0;
                    beat_s       = 4'd0;
                    if (read_en_r) begin
                        state_s = RWAIT;
                    end else begin
                        data_on_s = 1'b1;
                        state_s   = WDATA;
                    end
                end else begin
                    state_s = ADDR;
                end
            end
            WDATA: begin
                // Beat k (k >= 1) carries line word k-1, so the word index
                // for the next beat equals the beat being acked now.
                if (bus.resp_m_to_c) begin
                    if (beat_r == LAST_WRITE_BEAT) begin
                        data_on_s = 1'b0;
                        bus_s     = '0;
                        beat_s    = 4'd0;
                        state_s   = WDONE;
                    end else begin
                        beat_s = beat_r + 4'd1;
                        bus_s  = line_words_s[beat_r[2:0]];
                    end
                end else begin
                    state_s = WDATA;
                end
            end
            WDONE: begin
                if (bus.resp_m_to_c) begin
                    write_en_s = 1'b0;
                    dfp_resp_s = 1'b1;
                    state_s    = DONE;
                end else begin
                    state_s = WDONE;
                end
            end
            RWAIT: begin
                if (bus.resp_m_to_c) begin
                    capture_s = 1'b1;
                    if (beat_r == LAST_READ_BEAT) begin
                        read_en_s  = 1'b0;
                        dfp_resp_s = 1'b1;
                        beat_s     = 4'd0;
                        state_s    = DONE;
                    end else begin
                        beat_s = beat_r + 4'd1;
                    end
                end else begin
                    state_s = RWAIT;
                end
            end
            DONE: begin
                beat_s  = 4'd0;
                state_s = IDLE;
            end
            default: begin
                read_en_s    = 1'b0;
                write_en_s   = 1'b0;
                address_on_s = 1'b0;
                data_on_s    = 1'b0;
                bus_s        = '0;
                beat_s       = 4'd0;
                state_s      = IDLE;
            end
        endcase

        for (int k = 0; k < BEATS_PER_LINE; k++) begin
            line_s[k*BUS_WIDTH +: BUS_WIDTH] =
                (capture_s && (beat_r[2:0] == 3'(k))) ? bus.address_data_bus_m_to_c
                                                      : line_s[k*BUS_WIDTH +: BUS_WIDTH];
        end

        // A stuck responder ends the transaction early with a flagged completion.
        if (timeout_s) begin
            read_en_s    = 1'b0;
            write_en_s   = 1'b0;
            address_on_s = 1'b0;
            data_on_s    = 1'b0;
            bus_s        = '0;
            beat_s       = 4'd0;
            wait_s       = '0;
            dfp_resp_s   = 1'b1;
            err_s        = 1'b1;
            state_s      = DONE;
        end else begin
            err_s = err_r;
        end
    end

    // State, beat counter, line buffer and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            beat_r       <= 4'd0;
            line_r       <= '0;
            wait_cnt_r   <= '0;
            read_en_r    <= 1'b0;
            write_en_r   <= 1'b0;
            address_on_r <= 1'b0;
            data_on_r    <= 1'b0;
            bus_r        <= '0;
            dfp_resp_r   <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            beat_r       <= beat_s;
            line_r       <= line_s;
            wait_cnt_r   <= wait_s;
            read_en_r    <= read_en_s;
            write_en_r   <= write_en_s;
            address_on_r <= address_on_s;
            data_on_r    <= data_on_s;
            bus_r        <= bus_s;
            dfp_resp_r   <= dfp_resp_s;
            err_r        <= err_s;
        end
    end

    assign bus.read_en_c_to_m          = read_en_r;
    assign bus.write_en_c_to_m         = write_en_r;
    assign bus.address_on_c_to_m       = address_on_r;
    assign bus.data_on_c_to_m          = data_on_r;
    assign bus.address_data_bus_c_to_m = bus_r;
    assign dfp_rdata                   = line_r;
    assign dfp_resp                    = dfp_resp_r;
    assign err                         = err_r;

endmodule
